// File: rtl/inout_bus_pkg.sv
// inout_bus_pkg: state encoding and counter sizing shared by
// the inout bus owner arbiter and its round-robin picker.
package inout_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_e;

  // bits needed to hold the values 0..n
  function automatic int cnt_w(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

  // bits needed to index n requesters
  function automatic int idx_w(input int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/inout_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Ports: req (requests),
// last (previous owner) -> found (any request), idx (first set after last).
module rr_pick
  import inout_bus_pkg::*;
#(
  parameter int nreq = 4,
  parameter int iw   = idx_w(nreq)
) (
  input  logic [nreq-1:0] req,
  input  logic [iw-1:0]   last,
  output logic            found,
  output logic [iw-1:0]   idx
);

  logic [iw-1:0] j;

  // Walk from farthest to nearest so the nearest
  // requester after last is the final writer.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = nreq; k >= 1; k--) begin
      j = iw'((int'(last) + k) % nreq);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/inout_bus_arbiter.sv
// inout_bus_arbiter: round-robin owner arbiter for a shared tri-state bus
// with idle turnaround between tenures and a hold limit under contention.
// Ports: CLK, RST_N (sync, active-low); req/wr/wdata per requester;
// bus_din from the net; gnt, bus_oe, bus_dout, rdata, rdata_valid registered.
module inout_bus_arbiter
  import inout_bus_pkg::*;
#(
  parameter int width       = 8,
  parameter int nreq        = 4,
  parameter int turn_cycles = 1,
  parameter int max_hold    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [nreq-1:0]       req,
  input  logic [nreq-1:0]       wr,
  input  logic [nreq*width-1:0] wdata,
  input  logic [width-1:0]      bus_din,
  output logic [nreq-1:0]       gnt,
  output logic                  bus_oe,
  output logic [width-1:0]      bus_dout,
  output logic [width-1:0]      rdata,
  output logic                  rdata_valid
);

  localparam int IW = idx_w(nreq);
  localparam int HW = cnt_w(max_hold);
  localparam int TW = cnt_w(turn_cycles);

  localparam logic [HW-1:0] HOLD_MAX  = HW'(max_hold);
  localparam logic [TW-1:0] TURN_LAST = TW'(turn_cycles - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic            dir_q, dir_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   turn_q, turn_d;
  logic [nreq-1:0] gnt_q, gnt_d;
  logic            bus_oe_q, bus_oe_d;
  logic [width-1:0] bus_dout_q, bus_dout_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic            rdata_valid_q, rdata_valid_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [nreq-1:0] own_oh;
  logic [HW-1:0]   hold_inc;
  logic            others;
  logic [width-1:0] wd [nreq];

  for (genvar i = 0; i < nreq; i++) begin : g_wd
    assign wd[i] = wdata[i*width +: width];
  end

  rr_pick #(
    .nreq (nreq),
    .iw   (IW)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    dir_d         = dir_q;
    hold_d        = hold_q;
    turn_d        = turn_q;
    own_oh        = '0;
    own_oh[owner_q] = 1'b1;
    others        = |(req & ~own_oh);
    // hold_inc counts the current cycle, so a contended
    // tenure lasts exactly max_hold cycles.
    hold_inc      = (hold_q == HOLD_MAX) ? hold_q
                                         : hold_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          owner_d = pick_idx;
          last_d  = pick_idx;
          dir_d   = wr[pick_idx];
          hold_d  = '0;
        end
      end
      OWN: begin
        hold_d = hold_inc;
        if (!req[owner_q] ||
            (hold_inc == HOLD_MAX && others)) begin
          hold_d  = '0;
          turn_d  = '0;
          state_d = (turn_cycles > 0) ? TURN : IDLE;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the registered state one edge later.
    gnt_d         = (state_q == OWN) ? own_oh : '0;
    bus_oe_d      = (state_q == OWN) && dir_q;
    bus_dout_d    = bus_oe_d ? wd[owner_q] : '0;
    rdata_d       = bus_din;
    rdata_valid_d = (state_q == OWN) && !dir_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_q        <= IW'(nreq - 1);
      dir_q         <= 1'b0;
      hold_q        <= '0;
      turn_q        <= '0;
      gnt_q         <= '0;
      bus_oe_q      <= 1'b0;
      bus_dout_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      dir_q         <= dir_d;
      hold_q        <= hold_d;
      turn_q        <= turn_d;
      gnt_q         <= gnt_d;
      bus_oe_q      <= bus_oe_d;
      bus_dout_q    <= bus_dout_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign gnt         = gnt_q;
  assign bus_oe      = bus_oe_q;
  assign bus_dout    = bus_dout_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_inout_bus_arbiter.sv
// tb_inout_bus_arbiter: directed checks of grant order, hold limit,
// turnaround, read path and reset for two arbiter configurations.
module tb_inout_bus_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N-1:0]   req, wr;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   bus_din;

  logic [N-1:0] gnt_a, gnt_b;
  logic         oe_a, oe_b, rv_a, rv_b;
  logic [W-1:0] dout_a, dout_b, rd_a, rd_b;

  int n_cmp  = 0;
  int n_err  = 0;
  int ovl    = 0;
  int oe_bad = 0;

  logic [N-1:0] eg;
  logic [W-1:0] ed;

  always #5 CLK = ~CLK;

  inout_bus_arbiter #(
    .width(W), .nreq(N), .turn_cycles(1), .max_hold(4)
  ) u_a (
    .CLK(CLK), .RST_N(RST_N), .req(req), .wr(wr),
    .wdata(wdata), .bus_din(bus_din), .gnt(gnt_a),
    .bus_oe(oe_a), .bus_dout(dout_a), .rdata(rd_a),
    .rdata_valid(rv_a)
  );

  inout_bus_arbiter #(
    .width(W), .nreq(N), .turn_cycles(0), .max_hold(4)
  ) u_b (
    .CLK(CLK), .RST_N(RST_N), .req(req), .wr(wr),
    .wdata(wdata), .bus_din(bus_din), .gnt(gnt_b),
    .bus_oe(oe_b), .bus_dout(dout_b), .rdata(rd_b),
    .rdata_valid(rv_b)
  );

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1)
        ovl++;
      if ((oe_a && gnt_a == '0) || (oe_b && gnt_b == '0))
        oe_bad++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST_N   = 1'b0;
    req     = '0;
    wr      = '0;
    bus_din = '0;
    step();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N   = 1'b0;
    req     = '0;
    wr      = '0;
    wdata   = '0;
    bus_din = '0;
    step();
    step();
    RST_N = 1'b1;

    // reset state
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gnt_b", 32'(gnt_b), 0);
    chk("rst_oe", 32'(oe_a), 0);
    chk("rst_dout", 32'(dout_a), 0);
    chk("rst_rdata", 32'(rd_a), 0);
    chk("rst_rv", 32'(rv_a), 0);

    // single write tenure, then reset mid-tenure
    req = 4'b0001;
    wr  = 4'b0001;
    wdata[0 +: W] = 8'hA5;
    bus_din = 8'h33;
    step();
    chk("t1_lat_gnt", 32'(gnt_a), 0);
    step();
    chk("t1_gnt", 32'(gnt_a), 32'h1);
    chk("t1_oe", 32'(oe_a), 1);
    chk("t1_dout", 32'(dout_a), 32'hA5);
    chk("t1_rdata", 32'(rd_a), 32'h33);
    wdata[0 +: W] = 8'h5A;
    step();
    chk("t1_dout_trk", 32'(dout_a), 32'h5A);
    RST_N = 1'b0;
    step();
    chk("t1_mrst_gnt", 32'(gnt_a), 0);
    chk("t1_mrst_oe", 32'(oe_a), 0);
    chk("t1_mrst_dout", 32'(dout_a), 0);
    chk("t1_mrst_rdata", 32'(rd_a), 0);
    chk("t1_mrst_rv", 32'(rv_a), 0);
    RST_N = 1'b1;

    // round robin under full contention, max_hold 4, turn 1
    do_reset();
    req   = 4'b1111;
    wr    = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 1; c <= 29; c++) begin
      step();
      eg = '0;
      ed = '0;
      if (c >= 2) begin
        int k, t;
        k = (c - 2) % 6;
        t = (c - 2) / 6;
        if (k < 4) begin
          eg = 4'(1 << (t % 4));
          ed = 8'(((t % 4) + 1) * 17);
        end
      end
      chk($sformatf("rr_gnt c%0d", c), 32'(gnt_a), 32'(eg));
      chk($sformatf("rr_oe c%0d", c), 32'(oe_a),
          32'(eg != '0));
      chk($sformatf("rr_dout c%0d", c), 32'(dout_a), 32'(ed));
    end

    // uncontended tenure saturates, then yields to req[3]
    do_reset();
    req = 4'b0010;
    wr  = 4'b0010;
    step();
    chk("sat_lat", 32'(gnt_a), 0);
    for (int c = 0; c < 40; c++) begin
      step();
      chk($sformatf("sat_gnt c%0d", c), 32'(gnt_a), 32'h2);
    end
    req = 4'b1010;
    step();
    chk("sat_rel0", 32'(gnt_a), 32'h2);
    step();
    chk("sat_rel1", 32'(gnt_a), 0);
    step();
    chk("sat_turn", 32'(gnt_a), 0);
    step();
    chk("sat_g3", 32'(gnt_a), 32'h8);

    // read tenure by requester 2 with ramping bus
    do_reset();
    wr = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      logic ev;
      bus_din = 8'(8'h10 + i);
      req = (i < 5) ? 4'b0100 : 4'b0000;
      step();
      ev = (i >= 1 && i <= 5);
      chk($sformatf("rd_rdata i%0d", i), 32'(rd_a),
          32'(8'h10 + i));
      chk($sformatf("rd_oe i%0d", i), 32'(oe_a), 0);
      chk($sformatf("rd_rv i%0d", i), 32'(rv_a), 32'(ev));
      chk($sformatf("rd_gnt i%0d", i), 32'(gnt_a),
          ev ? 32'h4 : 0);
    end

    // zero turnaround handover on instance b
    do_reset();
    req = 4'b0011;
    wr  = 4'b0011;
    step();
    chk("z_e1", 32'(gnt_b), 0);
    step();
    chk("z_e2", 32'(gnt_b), 32'h1);
    req = 4'b0010;
    step();
    chk("z_e3", 32'(gnt_b), 32'h1);
    step();
    chk("z_gap", 32'(gnt_b), 0);
    step();
    chk("z_e5", 32'(gnt_b), 32'h2);
    step();
    chk("z_e6", 32'(gnt_b), 32'h2);

    // wr toggled mid-tenure only matters next tenure
    do_reset();
    req = 4'b0001;
    wr  = 4'b0001;
    wdata[0 +: W] = 8'h77;
    step();
    chk("wt_e1_oe", 32'(oe_a), 0);
    step();
    chk("wt_e2_oe", 32'(oe_a), 1);
    wr = 4'b0000;
    step();
    chk("wt_e3_oe", 32'(oe_a), 1);
    chk("wt_e3_dout", 32'(dout_a), 32'h77);
    step();
    chk("wt_e4_oe", 32'(oe_a), 1);
    req = 4'b0000;
    step();
    chk("wt_e5_oe", 32'(oe_a), 1);
    step();
    chk("wt_e6_gnt", 32'(gnt_a), 0);
    chk("wt_e6_oe", 32'(oe_a), 0);
    req = 4'b0001;
    step();
    chk("wt_e7_gnt", 32'(gnt_a), 0);
    step();
    chk("wt_e8_gnt", 32'(gnt_a), 32'h1);
    chk("wt_e8_oe", 32'(oe_a), 0);
    chk("wt_e8_dout", 32'(dout_a), 0);
    chk("wt_e8_rv", 32'(rv_a), 1);

    req = '0;
    step();
    step();
    chk("overlap_cycles", 32'(ovl), 0);
    chk("oe_without_gnt", 32'(oe_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inout_bus_arbiter.md
# inout_bus_arbiter

Round-robin owner arbiter for a shared bidirectional bus built from an `InoutConnect` net. Up to `nreq` requesters compete for bus tenure; the block grants one owner at a time and drives the single pad-side output enable and data. It inserts programmable idle turnaround cycles between tenures so no two drivers ever overlap on the wire. The block sits between requester logic and the top-level tri-state pad that feeds the `inout` connection.

## Interface
- `width`, 8, bus data width in bits
- `nreq`, 4, number of requesters (2..16)
- `turn_cycles`, 1, idle cycles between tenures (0..15)
- `max_hold`, 16, tenure cycles before forced release when others wait (≥1)

- `CLK`  in  1  single clock, all logic on rising edge
- `RST_N`  in  1  reset, synchronous, active-low
- `req`  in  nreq  per-requester tenure request, held while bus wanted
- `wr`  in  nreq  per-requester direction: 1 = drive bus, 0 = sample bus
- `wdata`  in  nreq*width  per-requester drive data, slice i = `[i*width +: width]`
- `bus_din`  in  width  value currently on the shared net
- `gnt`  out  nreq  one-hot grant, registered
- `bus_oe`  out  1  pad output enable, registered
- `bus_dout`  out  width  pad drive data, registered
- `rdata`  out  width  registered copy of `bus_din`
- `rdata_valid`  out  1  `rdata` captured during a read tenure

## Operation
- States: IDLE, OWN, TURN.
- IDLE: if any `req`, pick the first requester after `last` (wrapping) → load `owner`, `last`←`owner`, latch `wr[owner]` as `dir`, clear `hold_cnt`, go to OWN. Otherwise stay in IDLE.
- OWN:
  - `gnt` = one-hot(`owner`); `bus_oe` = `dir`.
  - `bus_dout` = `wdata[owner]` when `dir`=1, else 0.
  - `hold_cnt` increments, saturating at `max_hold`.
  - Changes to `wr` during a tenure are ignored.
- Leave OWN when `req[owner]`=0, or when `hold_cnt`=`max_hold` and another requester is pending. Go to TURN if `turn_cycles`>0, else IDLE.
- Uncontended tenure never expires: if only the owner requests, `hold_cnt` saturates and the grant continues.
- TURN: `gnt`=0, `bus_oe`=0; `turn_cnt` counts `turn_cycles`, then go to IDLE.
- Read path: `rdata`←`bus_din` every cycle. `rdata_valid` is 1 in cycles where the state was OWN with `dir`=0 on the previous edge.
- Reset (RST_N=0 at an edge), including mid-tenure:
  - state = IDLE, `gnt`=0, `bus_oe`=0, `bus_dout`=0, `rdata`=0, `rdata_valid`=0, counters = 0.
  - `last`=`nreq`-1, so requester 0 wins first.
- Invariant: `bus_oe`=1 only while `gnt` is nonzero. `gnt` has at most one bit set.

## Timing
- Grant latency: `req[i]` seen in IDLE at edge n → `gnt[i]` and `bus_oe` high after edge n+1.
- Release: `req[owner]` low at edge k → `gnt`/`bus_oe` low after edge k+1.
  - Next grant follows after edge k+2+`turn_cycles`.
  - Minimum bus-idle gap between drivers = `turn_cycles`+1 cycles.
- `bus_dout` tracks `wdata[owner]` with one-cycle register latency.
- Requests arriving during TURN wait for IDLE.
- Simultaneous requests resolve in round-robin order only.
- A requester dropping `req` before being granted loses nothing; it holds no state.

## Structure
- Shared package `inout_bus_pkg` holds:
  - state encoding constants (IDLE=2'd0, OWN=2'd1, TURN=2'd2)
  - counter-width helper for `max_hold`/`turn_cycles`
- Combinational sub-module `rr_pick`: inputs `req`, `last`; outputs `found` and `idx`. Finds the first set bit after `last`, with wrap.
- Arbiter FSM, counters and output registers live in `inout_bus_arbiter`.

## Test plan
- Reset then `req`=4'b0001, `wr[0]`=1, `wdata[0]`=8'hA5: `gnt`=0001 and `bus_oe`=1 one cycle later, `bus_dout`=A5. Assert `RST_N`=0 mid-tenure → all outputs 0 next edge.
- `req`=4'b1111 held continuously, `max_hold`=4, `turn_cycles`=1:
  - grants cycle 0,1,2,3,0 in order
  - each tenure exactly 4 cycles with `gnt`
  - exactly 2 idle cycles between tenures
- `req`=0010 alone for 40 cycles: `gnt[1]` stays high throughout (saturated, uncontended). Raise `req[3]` → release within 1 cycle, `gnt[3]` after the turnaround.
- Read tenure `wr[2]`=0, `bus_din` ramps 0x10,0x11,…: `bus_oe`=0, `rdata` lags `bus_din` one cycle, `rdata_valid` high only during tenure.
- `turn_cycles`=0, `req[0]` drops while `req[1]` pending: `gnt` goes 0001 → 0000 for exactly 1 cycle → 0010. Overlap checker reports zero cycles with two grants.
- Toggle `wr[owner]` mid-tenure: `bus_oe` unchanged until the next tenure.
